// File: rtl/rtc_write_sequencer.sv
// rtc_write_sequencer
// Replays up to 11 latched register bytes onto the RTC multiplexed AD bus as
// write transactions (address phase, then data phase) with programmable
// setup / pulse / hold / gap timing. The read path shares the bus and holds
// off while o_busy is high.
//
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_start          burst request, honoured only in IDLE
//   i_datos[87:0]    byte i at [8i+7:8i], latched on accepted start
//   i_mask[10:0]     bit i set means write byte i, latched on accepted start
//   o_ad_out         value driven on the AD bus
//   o_ad_oe          AD pad output enable
//   o_a_d            1 = address phase, 0 = data phase
//   o_cs_n, o_wr_n   chip select / write strobe, active low
//   o_rd_n           read strobe, always inactive here
//   o_busy           burst in progress
//   o_done           one-cycle pulse at burst end
//   o_byte_index     index of the byte currently being written
module rtc_write_sequencer #(
    parameter logic [7:0]  ADDR_BASE = 8'h21,
    parameter int unsigned T_SETUP   = 2,
    parameter int unsigned T_PULSE   = 3,
    parameter int unsigned T_HOLD    = 2,
    parameter int unsigned T_GAP     = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [87:0] i_datos,
    input  logic [10:0] i_mask,
    output logic [7:0]  o_ad_out,
    output logic        o_ad_oe,
    output logic        o_a_d,
    output logic        o_cs_n,
    output logic        o_wr_n,
    output logic        o_rd_n,
    output logic        o_busy,
    output logic        o_done,
    output logic [3:0]  o_byte_index
);

    typedef enum logic [3:0] {
        StIdle,
        StAddrSetup,
        StAddrPulse,
        StAddrHold,
        StDataSetup,
        StDataPulse,
        StDataHold,
        StGap,
        StDone
    } state_t;

    state_t      r_state, w_state_d;
    logic [7:0]  r_cnt, w_cnt_d;
    logic [3:0]  r_idx, w_idx_d;
    logic [87:0] r_data;
    logic [10:0] r_mask;
    logic        w_accept;
    logic [3:0]  w_first_idx;
    logic [3:0]  w_next_idx;
    logic        w_has_next;
    logic [7:0]  w_addr;
    logic [7:0]  w_byte;

    // Counter value loaded on entry so that a state lasts exactly its
    // parameter: the state exits on the cycle the counter reads zero.
    function automatic logic [7:0] load_val(state_t s);
        case (s)
            StAddrSetup, StDataSetup: load_val = 8'(T_SETUP - 1);
            StAddrPulse, StDataPulse: load_val = 8'(T_PULSE - 1);
            StAddrHold,  StDataHold:  load_val = 8'(T_HOLD - 1);
            StGap:                    load_val = 8'(T_GAP - 1);
            default:                  load_val = 8'd0;
        endcase
    endfunction

    // Lowest set bit of the incoming mask, and lowest latched bit above the
    // current index. Descending scan so the lowest match is written last.
    always_comb begin
        w_first_idx = 4'd0;
        w_next_idx  = 4'd0;
        w_has_next  = 1'b0;
        for (int i = 10; i >= 0; i--) begin
            if (i_mask[i]) begin
                w_first_idx = 4'(i);
            end
            if (r_mask[i] && (i > int'(r_idx))) begin
                w_next_idx = 4'(i);
                w_has_next = 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = (r_cnt == 8'd0) ? r_cnt : r_cnt - 8'd1;
        w_idx_d   = r_idx;
        w_accept  = 1'b0;

        case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_accept = 1'b1;
                    if (i_mask != 11'd0) begin
                        w_idx_d   = w_first_idx;
                        w_state_d = StAddrSetup;
                    end else begin
                        w_state_d = StDone;
                    end
                end
            end
            StAddrSetup: if (r_cnt == 8'd0) w_state_d = StAddrPulse;
            StAddrPulse: if (r_cnt == 8'd0) w_state_d = StAddrHold;
            StAddrHold:  if (r_cnt == 8'd0) w_state_d = StDataSetup;
            StDataSetup: if (r_cnt == 8'd0) w_state_d = StDataPulse;
            StDataPulse: if (r_cnt == 8'd0) w_state_d = StDataHold;
            StDataHold: begin
                if (r_cnt == 8'd0) begin
                    if (w_has_next) begin
                        w_idx_d   = w_next_idx;
                        w_state_d = StGap;
                    end else begin
                        w_state_d = StDone;
                    end
                end
            end
            StGap:       if (r_cnt == 8'd0) w_state_d = StAddrSetup;
            StDone:      w_state_d = StIdle;
            default:     w_state_d = StIdle;
        endcase

        if (w_state_d != r_state) begin
            w_cnt_d = load_val(w_state_d);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_cnt   <= 8'd0;
            r_idx   <= 4'd0;
            r_data  <= 88'd0;
            r_mask  <= 11'd0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_idx   <= w_idx_d;
            if (w_accept) begin
                r_data <= i_datos;
                r_mask <= i_mask;
            end
        end
    end

    assign w_addr = ADDR_BASE + {4'd0, r_idx};
    assign w_byte = r_data[{r_idx, 3'b000} +: 8];

    // Bus outputs decode straight from the state, so reset forces the bus
    // idle on the very next edge.
    always_comb begin
        o_cs_n   = 1'b1;
        o_wr_n   = 1'b1;
        o_a_d    = 1'b1;
        o_ad_oe  = 1'b0;
        o_ad_out = 8'h00;
        o_busy   = 1'b0;
        o_done   = 1'b0;

        case (r_state)
            StAddrSetup, StAddrPulse, StAddrHold: begin
                o_cs_n   = 1'b0;
                o_ad_oe  = 1'b1;
                o_ad_out = w_addr;
                o_wr_n   = (r_state != StAddrPulse);
                o_busy   = 1'b1;
            end
            StDataSetup, StDataPulse, StDataHold: begin
                o_cs_n   = 1'b0;
                o_a_d    = 1'b0;
                o_ad_oe  = 1'b1;
                o_ad_out = w_byte;
                o_wr_n   = (r_state != StDataPulse);
                o_busy   = 1'b1;
            end
            StGap:   o_busy = 1'b1;
            StDone:  o_done = 1'b1;
            default: ;
        endcase
    end

    assign o_rd_n       = 1'b1;
    assign o_byte_index = r_idx;

endmodule
